// File: rtl/l2_mem_model_if.sv
`default_nettype none
// ============================================================================
// l2_mem_model_if : request/response bundle between a bus controller and L2
// Revision: 1.0
// ============================================================================
interface l2_mem_model_if;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [31:0] l2store;
  logic [31:0] l2load;
  logic [1:0]  l2state;

  modport master (
    output l2REN, l2WEN, l2addr, l2store,
    input  l2load, l2state
  );

  modport slave (
    input  l2REN, l2WEN, l2addr, l2store,
    output l2load, l2state
  );
endinterface
`default_nettype wire

// File: rtl/l2_mem_model.sv
`default_nettype none
// ============================================================================
// l2_mem_model : single-ported fixed-latency L2 backing store
// Revision: 1.0
// ============================================================================
module l2_mem_model #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  l2_mem_model_if.slave bus
);
  localparam int unsigned c_AW       = $clog2(DEPTH);
  localparam int unsigned c_CW       = $clog2(LATENCY) + 1;
  localparam int unsigned c_CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [32:0] c_SPAN     = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  l2_state_t         state_q, state_d;
  logic              wr_q, wr_d;
  logic [c_AW-1:0]   idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mem [DEPTH];

  logic [32:0]       w_offset;
  logic              w_req_err;
  logic              w_any_req;

  // A borrow out of the 33-bit subtraction makes below-base addresses exceed c_SPAN
  assign w_offset  = {1'b0, bus.l2addr} - {1'b0, BASE_ADDR};
  assign w_any_req = bus.l2REN | bus.l2WEN;
  assign w_req_err = (bus.l2REN & bus.l2WEN) | (bus.l2addr[1:0] != 2'b00) |
                     (w_offset >= c_SPAN);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      L2_FREE: begin
        if (w_any_req) begin
          if (w_req_err) begin
            state_d = L2_ERROR;
          end else begin
            wr_d   = bus.l2WEN;
            idx_d  = w_offset[c_AW+1:2];
            data_d = bus.l2store;
            if (LATENCY == 1) begin
              state_d = L2_ACCESS;
            end else begin
              state_d = L2_BUSY;
              cnt_d   = c_CW'(c_CNT_INIT);
            end
          end
        end
      end
      L2_BUSY: begin
        if (!w_any_req) begin
          state_d = L2_FREE;
        end else if (cnt_q == '0) begin
          state_d = L2_ACCESS;
        end else begin
          cnt_d = cnt_q - c_CW'(1);
        end
      end
      default: state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= L2_FREE;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Commit lands at the end of ACCESS so the following FREE cycle sees the new data
  always_ff @(posedge CLK) begin
    if (!RST && state_q == L2_ACCESS && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  assign bus.l2load  = (state_q == L2_ACCESS && !wr_q) ? mem[idx_q] : 32'h0;
  assign bus.l2state = state_q;
endmodule
`default_nettype wire

// File: tb/tb_l2_mem_model.sv
`default_nettype none
// ============================================================================
// tb_l2_mem_model : randomized scoreboard bench for l2_mem_model
// Revision: 1.0
// ============================================================================
module tb_l2_mem_model;
  localparam int          LAT    = 4;
  localparam int          DEPTH0 = 1024;
  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam logic [1:0]  S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t sbq[$];
  logic [31:0] ref_mem [64];

  l2_mem_model_if bus0();
  l2_mem_model_if bus1();

  l2_mem_model #(.DEPTH(DEPTH0), .LATENCY(LAT), .BASE_ADDR(BASE0)) u_dut (
    .CLK(clk), .RST(rst), .bus(bus0)
  );

  l2_mem_model #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u_dut_l1 (
    .CLK(clk), .RST(rst), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every response pops the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus0.l2state == S_ACCESS || bus0.l2state == S_ERROR) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp: state %0d at cycle %0d, required no response", bus0.l2state, cyc);
        end else begin
          e = sbq.pop_front();
          if (bus0.l2state !== e.st || cyc != e.cyc || (e.chk_data && bus0.l2load !== e.data)) begin
            failures++;
            $display("FAIL resp: state %0d cycle %0d load %h, required state %0d cycle %0d load %h",
                     bus0.l2state, cyc, bus0.l2load, e.st, e.cyc, e.data);
          end
        end
      end else begin
        checks++;
        if (bus0.l2load !== 32'h0) begin
          failures++;
          $display("FAIL idle_load: got %h in state %0d, required 0", bus0.l2load, bus0.l2state);
        end
      end
    end
  end

  task automatic drop0();
    bus0.l2REN = 1'b0;
    bus0.l2WEN = 1'b0;
  endtask

  task automatic wait_resp(input int abort_j);
    logic [31:0] a0;
    a0 = bus0.l2addr;
    for (int n = 1; n <= 3 * LAT; n++) begin
      @(posedge clk); #1;
      if (abort_j != 0 && n == abort_j) begin
        drop0();
        @(posedge clk); #1;
        chk("abort_free", {30'h0, bus0.l2state}, {30'h0, S_FREE});
        return;
      end
      if (bus0.l2state == S_ACCESS || bus0.l2state == S_ERROR) begin
        drop0();
        @(posedge clk); #1;
        return;
      end
      // Operands wander while busy; the DUT must hold its latched copy
      bus0.l2addr  = a0 + 32'(4 * $urandom_range(1, 8));
      bus0.l2store = $urandom;
      case ($urandom_range(0, 2))
        0:       begin bus0.l2REN = 1'b1; bus0.l2WEN = 1'b0; end
        1:       begin bus0.l2REN = 1'b0; bus0.l2WEN = 1'b1; end
        default: begin bus0.l2REN = 1'b1; bus0.l2WEN = 1'b1; end
      endcase
    end
    checks++;
    failures++;
    $display("FAIL resp_timeout: no response within %0d cycles, required one", 3 * LAT);
    drop0();
    @(posedge clk); #1;
  endtask

  // op: 0 read, 1 write, 2 both enables high
  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] data, input int abort_j);
    exp_t e;
    bit   err;
    err = (op == 2) || (addr[1:0] != 2'b00) || (addr >= BASE0 + 32'(DEPTH0 * 4));
    bus0.l2REN   = (op != 1);
    bus0.l2WEN   = (op != 0);
    bus0.l2addr  = addr;
    bus0.l2store = data;
    if (abort_j == 0) begin
      e.chk_data = 1'b1;
      if (err) begin
        e.st = S_ERROR; e.data = 32'h0; e.cyc = cyc + 1;
      end else begin
        e.st = S_ACCESS; e.cyc = cyc + LAT;
        if (op == 0) begin
          e.data = ref_mem[addr[7:2]];
        end else begin
          e.data = 32'h0;
          ref_mem[addr[7:2]] = data;
        end
      end
      sbq.push_back(e);
    end
    wait_resp(abort_j);
  endtask

  initial begin
    exp_t e;
    int r;
    int ab;
    logic [31:0] a;
    drop0();
    bus0.l2addr = 32'h10; bus0.l2store = 32'h0;
    bus1.l2REN = 1'b0; bus1.l2WEN = 1'b0; bus1.l2addr = 32'h0; bus1.l2store = 32'h0;

    // Reset held two cycles with a read pending
    rst = 1'b1;
    bus0.l2REN = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_state", {30'h0, bus0.l2state}, {30'h0, S_FREE});
      chk("rst_load", bus0.l2load, 32'h0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    e = '{st: S_ACCESS, data: 32'h0, chk_data: 1'b0, cyc: cyc + LAT};
    sbq.push_back(e);
    wait_resp(0);

    for (int w = 0; w < 64; w++) issue(1, 32'(w * 4), $urandom, 0);

    issue(1, 32'h10, 32'hDEAD_BEEF, 0);
    issue(0, 32'h10, 32'h0, 0);
    issue(1, 32'h1002, 32'h1111_1111, 0);
    issue(1, BASE0 + 32'(DEPTH0 * 4), 32'h2222_2222, 0);
    issue(2, 32'h10, 32'h3333_3333, 0);
    issue(1, 32'h12, 32'h4444_4444, 0);
    issue(0, 32'h10, 32'h0, 0);

    issue(1, 32'h20, 32'h5555_5555, 2);
    issue(0, 32'h20, 32'h0, 0);

    issue(1, 32'h40, 32'h1234_5678, 0);
    issue(1, 32'h44, 32'hCAFE_F00D, 0);
    issue(0, 32'h40, 32'h0, 0);

    // Reset while busy must drop the write
    bus0.l2WEN = 1'b1; bus0.l2addr = 32'h30; bus0.l2store = 32'hBAD0_0BAD;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drop0();
    chk("rst_busy_free", {30'h0, bus0.l2state}, {30'h0, S_FREE});
    repeat (LAT + 1) begin @(posedge clk); #1; end
    issue(0, 32'h30, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      r  = int'($urandom_range(0, 99));
      a  = 32'($urandom_range(0, 63)) << 2;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
      if (r < 45)      issue(0, a, 32'h0, ab);
      else if (r < 85) issue(1, a, $urandom, ab);
      else if (r < 90) issue(2, a, $urandom, 0);
      else if (r < 95) issue(int'($urandom_range(0, 1)), a | 32'($urandom_range(1, 3)), $urandom, 0);
      else             issue(int'($urandom_range(0, 1)), 32'h1000 + (a << 4), $urandom, 0);
    end

    // LATENCY=1 instance: one-cycle turnaround and held-request reissue
    bus1.l2WEN = 1'b1; bus1.l2addr = 32'h1008; bus1.l2store = 32'hA5A5_0001;
    @(posedge clk); #1;
    chk("l1_wr_state", {30'h0, bus1.l2state}, {30'h0, S_ACCESS});
    chk("l1_wr_load", bus1.l2load, 32'h0);
    bus1.l2WEN = 1'b0;
    @(posedge clk); #1;
    chk("l1_wr_free", {30'h0, bus1.l2state}, {30'h0, S_FREE});
    bus1.l2REN = 1'b1;
    @(posedge clk); #1;
    chk("l1_rd_state", {30'h0, bus1.l2state}, {30'h0, S_ACCESS});
    chk("l1_rd_load", bus1.l2load, 32'hA5A5_0001);
    @(posedge clk); #1;
    chk("l1_rd_free", {30'h0, bus1.l2state}, {30'h0, S_FREE});
    chk("l1_free_load", bus1.l2load, 32'h0);
    @(posedge clk); #1;
    chk("l1_rd2_state", {30'h0, bus1.l2state}, {30'h0, S_ACCESS});
    chk("l1_rd2_load", bus1.l2load, 32'hA5A5_0001);
    bus1.l2addr = 32'h0FFC;
    @(posedge clk); #1;
    chk("l1_rd2_free", {30'h0, bus1.l2state}, {30'h0, S_FREE});
    @(posedge clk); #1;
    chk("l1_below_base", {30'h0, bus1.l2state}, {30'h0, S_ERROR});
    bus1.l2REN = 1'b0;
    @(posedge clk); #1;
    chk("l1_err_free", {30'h0, bus1.l2state}, {30'h0, S_FREE});

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/l2_mem_model.md
Name: l2_mem_model

Overview:
- Single-ported, fixed-latency L2 backing store on the L2 side of the coherence bus controller.
- Consumes the controller's l2REN/l2WEN/l2addr/l2store requests and reports progress on l2state using the l2_state_t encoding: L2_FREE, L2_BUSY, L2_ACCESS, L2_ERROR.
- Returns read data on l2load.
- Serves as the L2 for multicore simulation and as the reference responder on the bus controller bench.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing array; power of two, >= 2.
- LATENCY, 4, cycles from the accepted request to the L2_ACCESS cycle; >= 1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- l2REN  input  1  read request; held by the requester until it sees L2_ACCESS or L2_ERROR.
- l2WEN  input  1  write request; same hold rule as l2REN.
- l2addr  input  32  byte address, bus_word_t.
- l2store  input  32  write data, bus_word_t.
- l2load  output  32  read data; valid only while l2state == L2_ACCESS for a read.
- l2state  output  2  l2_state_t progress indication.

Interface:
- One clock; reset is synchronous and active-high.
- Clock port is CLK; reset port is RST.

Behaviour:
- Reset (RST high at an edge): state goes to FREE, l2state = L2_FREE, l2load = 0, latency counter = 0, latched request cleared. Array contents are not reset.
- RST overrides everything. Reset in BUSY aborts the transaction: no write commit.
- FSM states: FREE, BUSY, ACCESS, ERROR. l2state is the registered state encoding.

Request acceptance:
- In FREE, a request is accepted when (l2REN xor l2WEN) and the address is valid.
- Accepting latches the op, the word index (l2addr - BASE_ADDR)>>2, and l2store.
- If LATENCY == 1 the next state is ACCESS; otherwise BUSY with counter = LATENCY-2.

Error conditions (checked in FREE):
- Both l2REN and l2WEN high, or l2addr[1:0] != 0, or l2addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
- Any of these sends the FSM to ERROR for exactly one cycle, then back to FREE. No array access, l2load = 0.

BUSY:
- Counter decrements each cycle; when the counter is 0, the next state is ACCESS.
- Abort: if neither l2REN nor l2WEN is high in a BUSY cycle, return to FREE next cycle with no commit.
- Changes to l2addr, l2store, or op during BUSY are ignored; the latched values are used.

ACCESS (exactly one cycle, then FREE):
- Read: l2load = array[latched index], driven combinationally from the array during ACCESS.
- Write: the array is written at the end of the ACCESS cycle. l2load = 0.

Timing and back-to-back rules:
- Request first seen in FREE at cycle T gives ACCESS at cycle T+LATENCY.
- ACCESS/ERROR always return to FREE. A request still held in that FREE cycle is a new request; the requester must drop it after ACCESS.
- Minimum back-to-back spacing is LATENCY+1 cycles.
- Read-after-write to the same word returns the new data: the write is committed before the next FREE.

Width and arithmetic:
- Word index = (l2addr - BASE_ADDR)[clog2(DEPTH)+1:2].
- Counter width = clog2(LATENCY)+1; no wrap.

Test Plan:
- Reset: hold RST 2 cycles with l2REN=1 -> l2state=L2_FREE, l2load=0 during reset and the first cycle after; no ACCESS until LATENCY cycles after release.
- Write then read, LATENCY=4: write 32'hDEAD_BEEF to 0x10 (ACCESS exactly 4 cycles after request, then FREE); read 0x10 -> ACCESS 4 cycles later with l2load=32'hDEAD_BEEF for one cycle, 0 otherwise.
- Errors: l2addr=0x1002 -> L2_ERROR next cycle for one cycle; l2addr=BASE_ADDR+4*DEPTH -> L2_ERROR; REN=WEN=1 -> L2_ERROR; each followed by L2_FREE and array unchanged (read back prior values).
- Abort: write 0x5555_5555 to 0x20, deassert l2WEN in the second BUSY cycle -> FREE next cycle, never ACCESS; later read of 0x20 returns old value.
- Latched operands: start a read of 0x40 (holds 0x1234_5678), change l2addr to 0x44 during BUSY -> ACCESS returns 0x1234_5678.
- LATENCY=1 build: read request at cycle T -> ACCESS at T+1, FREE at T+2; held request at T+2 -> second ACCESS at T+3.
